// File: rtl/seg_scroll_scan_if.sv
// Bundle of the scroll/scan display signals between the lookup stage side and the back-end.
// The slave modport is the display back-end; the master modport is its environment.
interface seg_scroll_scan_if;
  logic       i_en;
  logic [6:0] i_seg_in;
  logic [2:0] o_sel;
  logic       o_step;
  logic [3:0] o_an;
  logic [6:0] o_seg_out;

  modport slave  (input  i_en, i_seg_in, output o_sel, o_step, o_an, o_seg_out);
  modport master (output i_en, i_seg_in, input  o_sel, o_step, o_an, o_seg_out);
endinterface

// File: rtl/seg_scroll_scan.sv
// Scrolling 4-digit window over an 8-digit lookup string, multiplexed onto a common-anode display.
// Optional macro SEG_SCROLL_BLANK_EN inserts one all-off anode cycle on every digit change.
module seg_scroll_scan #(
  parameter int STEP_DIV = 25000000,
  parameter int SCAN_DIV = 50000,
  parameter int STEP_W   = 25,
  parameter int SCAN_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scroll_scan_if.slave bus
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0]        BLANK     = 7'h7F;

  logic [STEP_W-1:0] r_step_cnt;
  logic              r_step;
  logic [2:0]        r_sel;
  logic              r_cap;
  logic [6:0]        r_buf [4];
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_scan_idx;
  logic [3:0]        r_an;
  logic [6:0]        r_seg_out;

  logic              w_step_tc;
  logic              w_scan_tc;
  logic [3:0]        w_an_onehot;
  logic [3:0]        w_an_next;

  assign w_step_tc = (r_step_cnt == STEP_LAST);
  assign w_scan_tc = (r_scan_cnt == SCAN_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_onehot[gi] = (r_scan_idx != 2'(gi));
    end
  endgenerate

  // Step tick: counts only enabled cycles, so a freeze resumes mid-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else if (bus.i_en) begin
      r_step_cnt <= w_step_tc ? '0 : r_step_cnt + 1'b1;
      r_step     <= w_step_tc;
    end else begin
      r_step     <= 1'b0;
    end
  end

  // cap starts at 1 so the sel=0 pattern is loaded right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= '0;
      r_cap <= 1'b1;
    end else begin
      r_cap <= r_step;
      if (r_step)
        r_sel <= r_sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        r_buf[i] <= BLANK;
    end else if (r_cap && bus.i_en) begin
      for (int i = 3; i > 0; i--)
        r_buf[i] <= r_buf[i-1];
      r_buf[0] <= bus.i_seg_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else begin
      r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_tc)
        r_scan_idx <= r_scan_idx + 1'b1;
    end
  end

`ifdef SEG_SCROLL_BLANK_EN
  logic [1:0] r_idx_prev;

  // A mismatch between current and previous index marks the first cycle of a new digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idx_prev <= '0;
    else
      r_idx_prev <= r_scan_idx;
  end

  assign w_an_next = (r_scan_idx != r_idx_prev) ? 4'b1111 : w_an_onehot;
`else
  assign w_an_next = w_an_onehot;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an      <= 4'b1110;
      r_seg_out <= BLANK;
    end else begin
      r_an      <= w_an_next;
      r_seg_out <= r_buf[r_scan_idx];
    end
  end

  assign bus.o_sel     = r_sel;
  assign bus.o_step    = r_step;
  assign bus.o_an      = r_an;
  assign bus.o_seg_out = r_seg_out;

endmodule

// File: doc/seg_scroll_scan.md
Name: seg_scroll_scan

Overview:
- Display back-end that sits directly downstream of the birth-digit lookup stage.
- Generates the step tick and the 3-bit index `sel` that drives the lookup stage, and captures the returned active-low 7-segment pattern.
- Shifts each captured pattern into a 4-digit scrolling window, so the 8-digit date string scrolls right-to-left.
- Time-multiplexes the window onto a 4-digit common-anode display.

Parameters:
- STEP_DIV, 25000000, clk cycles per scroll step (2 Hz at 50 MHz); legal range >= 2.
- SCAN_DIV, 50000, clk cycles each digit stays lit (1 kHz per digit at 50 MHz); legal range >= 2.
- STEP_W, 25, width of the step counter; must hold STEP_DIV-1.
- SCAN_W, 16, width of the scan counter; must hold SCAN_DIV-1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (acts on negedge rst); release is synchronous to clk.
- en  in  1  scroll enable; when 0, stepping and capture freeze and scanning continues.
- seg_in  in  7  active-low segment pattern from the lookup stage for the current `sel`; combinational w.r.t. `sel`.
- sel  out  3  digit index to the lookup stage.
- step  out  1  one-cycle pulse per scroll step.
- an  out  4  anode selects, active-low, one-hot-low.
- seg_out  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset values (rst low):
  - `sel`=0, `step`=0, step_cnt=0, scan_cnt=0, scan_idx=0.
  - cap=1.
  - buf[0..3]=7'h7F (blank).
  - `an`=4'b1110, `seg_out`=7'h7F.
- Step counter:
  - When en=1, step_cnt increments each cycle.
  - At STEP_DIV-1, step_cnt wraps to 0 and `step`=1 for that single cycle; otherwise `step`=0.
  - When en=0, step_cnt holds and `step`=0.
- Index: on the cycle after `step`=1, `sel` increments by 1, wrapping 7->0 (3-bit natural overflow).
- Capture flag: cap <= step (registered). cap=1 therefore coincides with the first cycle in which `sel` holds its new value.
- Capture:
  - On a posedge where cap=1 and en=1, the buffer shifts: buf[3]<=buf[2], buf[2]<=buf[1], buf[1]<=buf[0], buf[0]<=seg_in.
  - Because cap resets to 1, the pattern for sel=0 is loaded on the first posedge after reset release.
  - If en=0 while cap=1, the capture is dropped; cap clears and `sel` does not re-step.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 continuously, independent of en.
  - At terminal count, scan_idx <= scan_idx+1 (mod 4).
- Outputs: registered, one cycle after scan_idx/buf.
  - an[i]=0 iff scan_idx==i.
  - seg_out=buf[scan_idx].
  - Digit 0 (an[0]) is rightmost and shows the newest digit.
- Simultaneous events: a capture and a scan advance in the same cycle both take effect. The output register then shows the post-shift buffer at the new index on the next cycle.
- Reset mid-operation: all state returns to reset values immediately, with no partial shift.

Optional Feature:
- Macro: SEG_SCROLL_BLANK_EN.
- Defined: on every scan_idx change, `an` is forced to 4'b1111 for exactly one cycle (anti-ghosting), then the new digit is driven. `seg_out` is unaffected.
- Not defined: `an` switches directly from the old digit to the new one in a single cycle.

Test Plan (STEP_DIV=8, SCAN_DIV=4 unless noted):
- Reset:
  - Stimulus: hold rst=0 for 3 cycles.
  - Response: an=1110, seg_out=1111111, sel=0, step=0.
  - Stimulus: release rst.
  - Response: next cycle buf[0]=seg_in for sel=0 (7'b0100100, digit "2").
- Step timing:
  - Stimulus: en=1.
  - Response: step pulses every 8 cycles, 1 cycle wide; sel increments 0->1->...->7->0. Check over 9 steps.
- Scroll content:
  - Stimulus: after 3 steps, with seg_in driven as the lookup stage would (2,0,0,1).
  - Response: buf[3..0] = 0100100, 1000000, 1000000, 1111001.
  - Stimulus: after 8 steps total.
  - Response: buf[3..0] = digits 8,1,2,2 = 0000000, 1111001, 0100100, 0100100 (sel wrapped to 0, "2" reloaded).
- Scan rotation:
  - Stimulus: en=0.
  - Response: an sequence 1110, 1101, 1011, 0111 repeating, each held 4 cycles; seg_out matches buf[idx]; sel frozen.
- Enable freeze mid-step:
  - Stimulus: drop en at step_cnt=5 for 20 cycles, then raise it.
  - Response: step_cnt resumes at 5; next step occurs 3 cycles after en rises; no extra buffer shift.
- Anti-ghosting (build with SEG_SCROLL_BLANK_EN):
  - Response: one cycle of an=1111 precedes each digit change.
  - Build without the macro: never an=1111 after reset.
